// File: rtl/periph_bus_arbiter_if.sv
// Native peripheral bus bundle: request (valid/addr/wdata/wstrb) flows master->slave,
// completion (ready/rdata) flows back. wstrb == 0 marks a read.
interface periph_bus_arbiter_if;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/periph_bus_arbiter.sv
// Two-master (RR or fixed-priority) arbiter onto one peripheral slave: 1 idle arbitration cycle, then the
// granted request is forwarded until s.ready; losers wait. PERIPH_ARB_TIMEOUT_EN adds a hung-slave timeout.
module periph_bus_arbiter #(
  parameter int PRIO_MODE      = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  periph_bus_arbiter_if.slave   m0,
  periph_bus_arbiter_if.slave   m1,
  periph_bus_arbiter_if.master  s,
  output logic [1:0]            grant,
  output logic                  timeout_pulse,
  output logic [7:0]            timeout_count
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic [1:0]  grant_nxt;
  logic        rr_last, rr_last_nxt;  // 1 = m1 was served last
  logic        busy, gnt_valid, tmo_fire;
  logic        m0_ready_c, m1_ready_c, s_valid_c;
  logic [31:0] rdata_c, s_addr_c, s_wdata_c;
  logic [3:0]  s_wstrb_c;

  assign busy      = (state == BUSY);
  assign gnt_valid = (grant[0] & m0.valid) | (grant[1] & m1.valid);

`ifdef PERIPH_ARB_TIMEOUT_EN
  // busy_cnt holds the number of BUSY cycles already elapsed, so the timeout lands on BUSY cycle TIMEOUT_CYCLES
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] busy_cnt;
  logic [7:0]  tmo_cnt;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)           busy_cnt <= '0;
    else if (!busy)    busy_cnt <= '0;
    else if (!s.ready) busy_cnt <= busy_cnt + 16'd1;
  end

  assign tmo_fire = busy & gnt_valid & ~s.ready & (busy_cnt == TMO_LAST);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)                              tmo_cnt <= '0;
    else if (tmo_fire && tmo_cnt != 8'hFF) tmo_cnt <= tmo_cnt + 8'd1;
  end

  assign timeout_count = tmo_cnt;
`else
  assign tmo_fire      = 1'b0;
  assign timeout_count = '0;
`endif

  assign timeout_pulse = tmo_fire;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= 2'b00;
      rr_last <= 1'b1;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      rr_last <= rr_last_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    rr_last_nxt = rr_last;
    case (state)
      IDLE: begin
        if (m0.valid || m1.valid) begin
          state_nxt = BUSY;
          if (m0.valid && (!m1.valid || PRIO_MODE != 0 || rr_last)) grant_nxt = 2'b01;
          else                                                      grant_nxt = 2'b10;
        end
      end
      BUSY: begin
        if (s.ready || tmo_fire) begin
          state_nxt   = IDLE;
          grant_nxt   = 2'b00;
          rr_last_nxt = grant[1];
        end else if (!gnt_valid) begin
          // requester withdrew: drop the transaction without touching fairness state
          state_nxt = IDLE;
          grant_nxt = 2'b00;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

  always_comb begin
    m0_ready_c = busy & grant[0] & (s.ready | tmo_fire);
    m1_ready_c = busy & grant[1] & (s.ready | tmo_fire);
    rdata_c    = s.ready ? s.rdata : 32'hDEAD_BEEF;
    s_valid_c  = busy & gnt_valid & ~tmo_fire;
    s_addr_c   = '0;
    s_wdata_c  = '0;
    s_wstrb_c  = '0;
    if (busy && grant[0]) begin
      s_addr_c  = m0.addr;
      s_wdata_c = m0.wdata;
      s_wstrb_c = m0.wstrb;
    end else if (busy && grant[1]) begin
      s_addr_c  = m1.addr;
      s_wdata_c = m1.wdata;
      s_wstrb_c = m1.wstrb;
    end
  end

  assign m0.ready = m0_ready_c;
  assign m1.ready = m1_ready_c;
  assign m0.rdata = m0_ready_c ? rdata_c : '0;
  assign m1.rdata = m1_ready_c ? rdata_c : '0;
  assign s.valid  = s_valid_c;
  assign s.addr   = s_addr_c;
  assign s.wdata  = s_wdata_c;
  assign s.wstrb  = s_wstrb_c;

endmodule
